// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: FSM encoding and the default bus-wait limit.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    localparam logic [1:0] LSU_ST_IDLE = 2'd0;
    localparam logic [1:0] LSU_ST_REQ  = 2'd1;
    localparam logic [1:0] LSU_ST_WAIT = 2'd2;
    localparam logic [1:0] LSU_ST_DONE = 2'd3;

    localparam int LSU_TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/lsu_watchdog.sv
// Bus-wait counter for lsu_ctrl; only instantiated when LSU_TIMEOUT_EN is defined.
module lsu_watchdog
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_r;

    // Fires in the cycle whose edge makes the count reach TIMEOUT_CYCLES.
    assign expired = en & (count_r == CNT_LAST);

    // Wait-cycle counter, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (en && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns isLoad/isStore into a req/gnt/rvalid bus transaction and stalls the core meanwhile.
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              isLoad,
    input  logic              isStore,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] memWdata,
    input  logic [3:0]        memWMask,
    output logic              stall,
    output logic [DATA_W-1:0] memRdata,
    output logic              lsu_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_wmask,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    logic [1:0] state_r;
    logic       mem_op_s;
    logic       is_store_s;
    logic       timeout_s;
    logic       unused_addr_s;

    assign mem_op_s      = isLoad | isStore;
    // Both strobes high is treated as a load.
    assign is_store_s    = isStore & ~isLoad;
    assign stall         = mem_op_s & (state_r != LSU_ST_DONE);
    assign unused_addr_s = ^addr[1:0];

`ifdef LSU_TIMEOUT_EN
    logic wd_clr_s;
    logic wd_en_s;

    assign wd_clr_s = (state_r == LSU_ST_IDLE) & mem_op_s;
    assign wd_en_s  = (state_r == LSU_ST_REQ) | (state_r == LSU_ST_WAIT);

    lsu_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (reset),
        .clr     (wd_clr_s),
        .en      (wd_en_s),
        .expired (timeout_s)
    );
`else
    logic unused_cfg_s;

    assign timeout_s    = 1'b0;
    assign unused_cfg_s = (TIMEOUT_CYCLES > 0);
`endif

    // Transaction FSM with registered bus fields, load data and error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= LSU_ST_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wmask <= 4'b0000;
            memRdata  <= '0;
            lsu_err   <= 1'b0;
        end else begin
            case (state_r)
                LSU_ST_IDLE: begin
                    lsu_err <= 1'b0;
                    if (mem_op_s) begin
                        state_r   <= LSU_ST_REQ;
                        bus_req   <= 1'b1;
                        bus_we    <= is_store_s;
                        bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        bus_wdata <= memWdata;
                        bus_wmask <= is_store_s ? memWMask : 4'b0000;
                    end else begin
                        state_r <= LSU_ST_IDLE;
                    end
                end
                LSU_ST_REQ: begin
                    if (timeout_s) begin
                        state_r <= LSU_ST_DONE;
                        bus_req <= 1'b0;
                        lsu_err <= 1'b1;
                        if (!bus_we) begin
                            memRdata <= '0;
                        end
                    end else if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state_r <= bus_we ? LSU_ST_DONE : LSU_ST_WAIT;
                    end else begin
                        state_r <= LSU_ST_REQ;
                    end
                end
                LSU_ST_WAIT: begin
                    if (timeout_s) begin
                        state_r  <= LSU_ST_DONE;
                        lsu_err  <= 1'b1;
                        memRdata <= '0;
                    end else if (bus_rvalid) begin
                        state_r  <= LSU_ST_DONE;
                        memRdata <= bus_rdata;
                    end else begin
                        state_r <= LSU_ST_WAIT;
                    end
                end
                LSU_ST_DONE: begin
                    state_r <= LSU_ST_IDLE;
                    lsu_err <= 1'b0;
                end
                default: begin
                    state_r <= LSU_ST_IDLE;
                    bus_req <= 1'b0;
                    lsu_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: stores, loads, reset mid-transaction, back-to-back loads and optional timeout.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        isLoad;
    logic        isStore;
    logic [31:0] addr;
    logic [31:0] memWdata;
    logic [3:0]  memWMask;
    logic        stall;
    logic [31:0] memRdata;
    logic        lsu_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .isLoad     (isLoad),
        .isStore    (isStore),
        .addr       (addr),
        .memWdata   (memWdata),
        .memWMask   (memWMask),
        .stall      (stall),
        .memRdata   (memRdata),
        .lsu_err    (lsu_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wmask  (bus_wmask),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic after_pos();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; isLoad = 1'b0; isStore = 1'b0; addr = 32'h0;
        memWdata = 32'h0; memWMask = 4'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;

        repeat (2) @(negedge clk);
        chk("rst_bus_req",   {31'd0, bus_req},   32'd0);
        chk("rst_bus_we",    {31'd0, bus_we},    32'd0);
        chk("rst_bus_addr",  bus_addr,           32'h0);
        chk("rst_bus_wdata", bus_wdata,          32'h0);
        chk("rst_bus_wmask", {28'd0, bus_wmask}, 32'd0);
        chk("rst_memrdata",  memRdata,           32'h0);
        chk("rst_lsu_err",   {31'd0, lsu_err},   32'd0);
        reset = 1'b0;

        // Store, grant in first REQ cycle
        after_pos();
        isStore = 1'b1; addr = 32'h1006; memWMask = 4'b1100; memWdata = 32'hA5A5_A5A5;
        #1;
        chk("st_idle_stall", {31'd0, stall},   32'd1);
        chk("st_idle_req",   {31'd0, bus_req}, 32'd0);
        after_pos();
        bus_gnt = 1'b1;
        @(negedge clk);
        chk("st_req_req",   {31'd0, bus_req},   32'd1);
        chk("st_req_addr",  bus_addr,           32'h1004);
        chk("st_req_we",    {31'd0, bus_we},    32'd1);
        chk("st_req_wmask", {28'd0, bus_wmask}, 32'hC);
        chk("st_req_wdata", bus_wdata,          32'hA5A5_A5A5);
        chk("st_req_stall", {31'd0, stall},     32'd1);
        after_pos();
        bus_gnt = 1'b0;
        @(negedge clk);
        chk("st_done_stall", {31'd0, stall},   32'd0);
        chk("st_done_req",   {31'd0, bus_req}, 32'd0);
        chk("st_done_rdata", memRdata,         32'h0);
        after_pos();
        isStore = 1'b0;
        @(negedge clk);
        chk("st_idle2_stall", {31'd0, stall},   32'd0);
        chk("st_idle2_req",   {31'd0, bus_req}, 32'd0);

        // Load, grant on the fourth REQ cycle, stray rvalid in REQ ignored
        isLoad = 1'b1; addr = 32'h2000; memWMask = 4'b1111; memWdata = 32'h5555_5555;
        #1;
        chk("ld_idle_stall", {31'd0, stall}, 32'd1);
        after_pos();
        for (int i = 0; i < 4; i++) begin
            bus_gnt    = (i == 3);
            bus_rvalid = (i == 1);
            bus_rdata  = 32'h1111_1111;
            @(negedge clk);
            chk("ld_req_req",   {31'd0, bus_req},   32'd1);
            chk("ld_req_addr",  bus_addr,           32'h2000);
            chk("ld_req_we",    {31'd0, bus_we},    32'd0);
            chk("ld_req_wmask", {28'd0, bus_wmask}, 32'd0);
            chk("ld_req_stall", {31'd0, stall},     32'd1);
            after_pos();
        end
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        @(negedge clk);
        chk("ld_wait1_req",   {31'd0, bus_req}, 32'd0);
        chk("ld_wait1_stall", {31'd0, stall},   32'd1);
        chk("ld_stray_rdata", memRdata,         32'h0);
        after_pos();
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        after_pos();
        bus_rvalid = 1'b0; bus_rdata = 32'h0;
        @(negedge clk);
        chk("ld_done_rdata", memRdata,         32'hDEAD_BEEF);
        chk("ld_done_stall", {31'd0, stall},   32'd0);
        chk("ld_done_req",   {31'd0, bus_req}, 32'd0);
        after_pos();
        isLoad = 1'b0;

        // Non-memory stream with bus_gnt toggling outside REQ
        for (int i = 0; i < 5; i++) begin
            addr    = 32'h100 * i;
            bus_gnt = i[0];
            @(negedge clk);
            chk("nm_stall", {31'd0, stall},   32'd0);
            chk("nm_req",   {31'd0, bus_req}, 32'd0);
            after_pos();
        end
        bus_gnt = 1'b0;

        // Reset asserted during WAIT
        isLoad = 1'b1; addr = 32'h3008;
        after_pos();
        bus_gnt = 1'b1;
        after_pos();
        bus_gnt = 1'b0;
        @(negedge clk);
        chk("rw_pre_rdata", memRdata, 32'hDEAD_BEEF);
        reset = 1'b1;
        #1;
        chk("rw_req",   {31'd0, bus_req}, 32'd0);
        chk("rw_stall", {31'd0, stall},   32'd1);
        chk("rw_rdata", memRdata,         32'h0);
        chk("rw_addr",  bus_addr,         32'h0);
        after_pos();
        reset = 1'b0;
        after_pos();
        bus_gnt = 1'b1;
        @(negedge clk);
        chk("rw_new_req",  {31'd0, bus_req}, 32'd1);
        chk("rw_new_addr", bus_addr,         32'h3008);
        after_pos();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rw_new_wait_stall", {31'd0, stall}, 32'd1);
        after_pos();
        bus_rvalid = 1'b0;
        @(negedge clk);
        chk("rw_new_rdata", memRdata,       32'h1234_5678);
        chk("rw_new_stall", {31'd0, stall}, 32'd0);

        // Two consecutive loads, the second with both strobes high
        after_pos();
        addr = 32'h4000;
        @(negedge clk);
        chk("b2b_idle1_stall", {31'd0, stall},   32'd1);
        chk("b2b_idle1_req",   {31'd0, bus_req}, 32'd0);
        after_pos();
        bus_gnt = 1'b1;
        @(negedge clk);
        chk("b2b_req1_addr", bus_addr, 32'h4000);
        after_pos();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        after_pos();
        bus_rvalid = 1'b0;
        @(negedge clk);
        chk("b2b_done1_rdata", memRdata,       32'hCAFE_F00D);
        chk("b2b_done1_stall", {31'd0, stall}, 32'd0);
        after_pos();
        addr = 32'h4006; isStore = 1'b1; memWMask = 4'b1111; memWdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("b2b_idle2_stall", {31'd0, stall},   32'd1);
        chk("b2b_idle2_req",   {31'd0, bus_req}, 32'd0);
        after_pos();
        bus_gnt = 1'b1;
        @(negedge clk);
        chk("b2b_req2_req",   {31'd0, bus_req},   32'd1);
        chk("b2b_req2_addr",  bus_addr,           32'h4004);
        chk("b2b_req2_we",    {31'd0, bus_we},    32'd0);
        chk("b2b_req2_wmask", {28'd0, bus_wmask}, 32'd0);
        after_pos();
        bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_C0DE;
        after_pos();
        bus_rvalid = 1'b0;
        @(negedge clk);
        chk("b2b_done2_rdata", memRdata,       32'h0BAD_C0DE);
        chk("b2b_done2_stall", {31'd0, stall}, 32'd0);
        after_pos();
        isLoad = 1'b0; isStore = 1'b0;

        // Store with one-cycle grant delay leaves memRdata alone
        isStore = 1'b1; addr = 32'h5003; memWMask = 4'b0001; memWdata = 32'h0000_00EE;
        after_pos();
        @(negedge clk);
        chk("st2_req_req",   {31'd0, bus_req},   32'd1);
        chk("st2_req_addr",  bus_addr,           32'h5000);
        chk("st2_req_we",    {31'd0, bus_we},    32'd1);
        chk("st2_req_wmask", {28'd0, bus_wmask}, 32'h1);
        after_pos();
        bus_gnt = 1'b1;
        @(negedge clk);
        chk("st2_req2_stall", {31'd0, stall}, 32'd1);
        after_pos();
        bus_gnt = 1'b0;
        @(negedge clk);
        chk("st2_done_stall", {31'd0, stall}, 32'd0);
        chk("st2_done_rdata", memRdata,       32'h0BAD_C0DE);
        after_pos();
        isStore = 1'b0;

`ifdef LSU_TIMEOUT_EN
        // Load that is never granted times out after 8 counted cycles
        isLoad = 1'b1; addr = 32'h6000;
        after_pos();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("to_req_req", {31'd0, bus_req}, 32'd1);
            chk("to_req_err", {31'd0, lsu_err}, 32'd0);
            after_pos();
        end
        @(negedge clk);
        chk("to_done_err",   {31'd0, lsu_err}, 32'd1);
        chk("to_done_req",   {31'd0, bus_req}, 32'd0);
        chk("to_done_rdata", memRdata,         32'h0);
        chk("to_done_stall", {31'd0, stall},   32'd0);
        after_pos();
        isLoad = 1'b0;
        @(negedge clk);
        chk("to_idle_err", {31'd0, lsu_err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer for the single-cycle core. It converts the datapath's combinational `isLoad`/`isStore` memory access into a multi-cycle request/grant/response transaction on an external data bus. While the access is in flight it asserts `stall`, which freezes the PC register and gates `regWrite`. It returns the fetched word on `memRdata`, which feeds the datapath's load-extraction logic unchanged.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYCLES`, 255, bus-wait limit in cycles; used only with the timeout feature

- `clk`  in  1  core clock
- `reset`  in  1  asynchronous, active-high reset
- `isLoad`  in  1  current instruction is a load
- `isStore`  in  1  current instruction is a store
- `addr`  in  ADDR_W  byte address (datapath `aluOut`)
- `memWdata`  in  DATA_W  lane-replicated store data
- `memWMask`  in  4  byte-enable mask
- `stall`  out  1  hold PC and suppress `regWrite`
- `memRdata`  out  DATA_W  registered load word
- `lsu_err`  out  1  one-cycle bus timeout pulse
- `bus_req`  out  1  request valid
- `bus_we`  out  1  1 = write, 0 = read
- `bus_addr`  out  ADDR_W  word-aligned address
- `bus_wdata`  out  DATA_W  write data
- `bus_wmask`  out  4  write byte enables
- `bus_gnt`  in  1  request accepted this cycle
- `bus_rvalid`  in  1  read data valid
- `bus_rdata`  in  DATA_W  read data

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - Trigger: `isLoad | isStore`.
  - On trigger, register the bus fields and go to REQ.
  - `bus_addr` = `{addr[ADDR_W-1:2], 2'b00}`.
  - `bus_we` = `isStore & ~isLoad`.
  - `bus_wmask` = `memWMask` for a store, 0 for a load.
  - `bus_wdata` = `memWdata`.
- **REQ**
  - `bus_req` = 1. All bus fields stay stable until `bus_gnt`.
  - On `bus_gnt`: a store goes to DONE; a load goes to WAIT.
- **WAIT**
  - On `bus_rvalid`: capture `bus_rdata` into `memRdata`, go to DONE.
- **DONE**
  - `stall` = 0 for exactly one cycle, so the instruction retires at this edge.
  - Unconditionally return to IDLE.
- `stall` = `(isLoad | isStore) & (state != DONE)`. This is combinational, so it asserts in the same cycle a memory instruction appears.
- Non-memory instructions never stall; the FSM stays in IDLE.
- `isLoad` and `isStore` both high is illegal; the access is treated as a load.
- `memRdata` holds its value until the next load capture. Stores do not alter it.

## Timing
- Reset values:
  - state IDLE.
  - `bus_req`, `bus_we`, `lsu_err` = 0.
  - `bus_addr`, `bus_wdata`, `bus_wmask`, `memRdata` = 0.
- Reset is asynchronous, so it drops `bus_req` immediately, even mid-transaction.
- Minimum latency with `bus_gnt` in the first REQ cycle:
  - Store: 3 cycles (IDLE, REQ, DONE).
  - Load: 4 cycles (IDLE, REQ, WAIT, DONE), with `bus_rvalid` on the first WAIT cycle.
- `bus_rvalid` in REQ is ignored. The bus guarantees `bus_rvalid` at least one cycle after `bus_gnt`.
- `bus_gnt` outside REQ is ignored.
- Back-to-back memory instructions: the next instruction is sampled in the IDLE following DONE. There is no pipelining and at most one outstanding transaction.

## Configuration
- Macro: `LSU_TIMEOUT_EN`.
- **Defined**
  - A counter clears on entry to REQ and increments in REQ and WAIT.
  - When it reaches `TIMEOUT_CYCLES`, the FSM forces DONE.
  - `lsu_err` = 1 during that DONE cycle.
  - A timed-out load writes 0 to `memRdata`.
  - `bus_req` drops on the timeout transition.
- **Undefined**
  - No counter. The FSM waits indefinitely.
  - `lsu_err` is tied to 0.
  - The port list is identical in both builds.

## Structure
- Package `lsu_pkg` holds:
  - The state enum typedef `lsu_state_t`.
  - Localparams `LSU_ST_IDLE/REQ/WAIT/DONE`.
  - The default `TIMEOUT_CYCLES`.
- One sub-module, `lsu_watchdog`:
  - Parameterised timeout counter with `clr`/`en` inputs and an `expired` output.
  - Width is `$clog2(TIMEOUT_CYCLES+1)`.
  - Instantiated only under `LSU_TIMEOUT_EN`.

## Test plan
- Store `addr`=0x1006, `memWMask`=0b1100, `bus_gnt` on first REQ cycle -> `bus_addr`=0x1004, `bus_we`=1, `bus_wmask`=0b1100; `stall` high 2 cycles, low in DONE.
- Load `addr`=0x2000, `bus_gnt` after 3 REQ cycles, `bus_rvalid`+`bus_rdata`=0xDEADBEEF 2 cycles later -> `bus_req`/fields stable throughout REQ; `memRdata`=0xDEADBEEF in DONE; `bus_wmask`=0.
- Non-memory instruction stream -> `stall`=0 and `bus_req`=0 on every cycle.
- Reset asserted during WAIT -> `bus_req`=0 and `stall` follows IDLE immediately; after release, a new load completes normally.
- Two consecutive loads -> two separate transactions, second sampled in the IDLE after the first DONE; `memRdata` updates on each.
- With `LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `bus_gnt` never asserted -> DONE after 8 counted cycles, `lsu_err` one-cycle pulse, `memRdata`=0.
